// File: rtl/cmd_receiver_pkg.sv
// Shared constants and types for the ASCII command receiver.
// Holds character codes, FSM encoding and pulse bit positions.
package cmd_receiver_pkg;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_LZ = 8'h7A;
    localparam logic [7:0] ASC_G  = 8'h47;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_V  = 8'h56;
    localparam logic [7:0] ASC_W  = 8'h57;
    localparam logic [7:0] ASC_U  = 8'h55;
    localparam logic [7:0] ASC_D  = 8'h44;
    localparam logic [7:0] ASC_T  = 8'h54;

    localparam int NPLS    = 9;
    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_CLEAR = 2;
    localparam int P_SAVE  = 3;
    localparam int P_WTIME = 4;
    localparam int P_SR04  = 5;
    localparam int P_DHT   = 6;
    localparam int P_SET   = 7;
    localparam int P_ERR   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_TIME,
        S_ERR
    } state_t;

    typedef logic [NPLS-1:0] pls_t;

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASC_CR) || (c == ASC_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASC_0) && (c <= ASC_9);
    endfunction

    // One-hot trigger for a single-letter command; zero if not one.
    function automatic pls_t cmd_pulse(input logic [7:0] c);
        pls_t p;
        p = '0;
        case (c)
            ASC_G:   p[P_START] = 1'b1;
            ASC_P:   p[P_STOP]  = 1'b1;
            ASC_C:   p[P_CLEAR] = 1'b1;
            ASC_V:   p[P_SAVE]  = 1'b1;
            ASC_W:   p[P_WTIME] = 1'b1;
            ASC_U:   p[P_SR04]  = 1'b1;
            ASC_D:   p[P_DHT]   = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cmd_receiver_ascii_dec2.sv
// Two ASCII digits to a binary 0..99 value.
// valid is low if either byte is not a decimal digit.
module ascii_dec2
    import cmd_receiver_pkg::*;
(
    input  logic [7:0] tens,
    input  logic [7:0] units,
    output logic [6:0] value,
    output logic       valid
);

    logic [7:0] t_d;
    logic [7:0] u_d;

    assign t_d   = tens - ASC_0;
    assign u_d   = units - ASC_0;
    assign valid = is_digit(tens) && is_digit(units);
    assign value = (t_d[6:0] * 7'd10) + u_d[6:0];

endmodule

// File: rtl/cmd_receiver.sv
// Line-oriented ASCII command parser fed from an FWFT RX FIFO.
// Emits one-cycle trigger pulses and a registered time-set value.
module cmd_receiver
    import cmd_receiver_pkg::*;
#(
    parameter bit CASE_INS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] i_data,
    output logic       pop,
    output logic       sw_start_trig,
    output logic       sw_stop_trig,
    output logic       sw_clear_trig,
    output logic       sw_save_trig,
    output logic       w_time_trig,
    output logic       sr04_dist_trig,
    output logic       dht11_trig,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       set_time_trig,
    output logic       cmd_err
);

    state_t          state, state_nx;
    logic [2:0]      cnt, cnt_nx;
    logic [5:0][7:0] dig, dig_nx;
    logic [7:0]      cmd, cmd_nx;
    pls_t            pls, pls_nx;
    logic            set_ld;
    logic [7:0]      ub;
    logic [6:0]      h_val, m_val, s_val;
    logic            h_ok, m_ok, s_ok;
    logic            time_ok;

    ascii_dec2 u_dec_h (.tens(dig[0]), .units(dig[1]), .value(h_val), .valid(h_ok));
    ascii_dec2 u_dec_m (.tens(dig[2]), .units(dig[3]), .value(m_val), .valid(m_ok));
    ascii_dec2 u_dec_s (.tens(dig[4]), .units(dig[5]), .value(s_val), .valid(s_ok));

    assign time_ok = h_ok && m_ok && s_ok && (h_val <= 7'd23) &&
                     (m_val <= 7'd59) && (s_val <= 7'd59);

    assign ub = (CASE_INS && (i_data >= ASC_LA) && (i_data <= ASC_LZ)) ?
                (i_data - 8'h20) : i_data;

    assign pop = !empty && !rst;

    assign sw_start_trig  = pls[P_START];
    assign sw_stop_trig   = pls[P_STOP];
    assign sw_clear_trig  = pls[P_CLEAR];
    assign sw_save_trig   = pls[P_SAVE];
    assign w_time_trig    = pls[P_WTIME];
    assign sr04_dist_trig = pls[P_SR04];
    assign dht11_trig     = pls[P_DHT];
    assign set_time_trig  = pls[P_SET];
    assign cmd_err        = pls[P_ERR];

    // Next state, digit capture and the pulse to fire next cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dig_nx   = dig;
        cmd_nx   = cmd;
        pls_nx   = '0;
        set_ld   = 1'b0;
        if (!empty) begin
            unique case (state)
                S_IDLE: begin
                    if (is_term(i_data)) begin
                        state_nx = S_IDLE;
                    end else if (ub == ASC_T) begin
                        cnt_nx   = 3'd0;
                        state_nx = S_TIME;
                    end else if (cmd_pulse(ub) != '0) begin
                        cmd_nx   = ub;
                        state_nx = S_CMD;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                S_CMD: begin
                    if (is_term(i_data)) begin
                        pls_nx   = cmd_pulse(cmd);
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                S_TIME: begin
                    if (is_term(i_data)) begin
                        if ((cnt == 3'd6) && time_ok) begin
                            pls_nx[P_SET] = 1'b1;
                            set_ld        = 1'b1;
                        end else begin
                            pls_nx[P_ERR] = 1'b1;
                        end
                        state_nx = S_IDLE;
                    end else if (is_digit(i_data) && (cnt < 3'd6)) begin
                        for (int i = 0; i < 6; i++) begin
                            if (cnt == 3'(i)) dig_nx[i] = i_data;
                        end
                        cnt_nx = cnt + 3'd1;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_term(i_data)) begin
                        pls_nx[P_ERR] = 1'b1;
                        state_nx      = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Parser state, pulse register and time-set value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            dig      <= '0;
            cmd      <= 8'h00;
            pls      <= '0;
            set_hour <= 5'd0;
            set_min  <= 6'd0;
            set_sec  <= 6'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dig   <= dig_nx;
            cmd   <= cmd_nx;
            pls   <= pls_nx;
            if (set_ld) begin
                set_hour <= h_val[4:0];
                set_min  <= m_val[5:0];
                set_sec  <= s_val[5:0];
            end
        end
    end

endmodule

// File: tb/tb_cmd_receiver.sv
// Scoreboard bench for cmd_receiver.
// A whole-line model predicts each pulse, its cycle and set_* values.
module tb_cmd_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       pop;
    logic       sw_start_trig, sw_stop_trig, sw_clear_trig, sw_save_trig;
    logic       w_time_trig, sr04_dist_trig, dht11_trig;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       set_time_trig, cmd_err;

    cmd_receiver #(.CASE_INS(1'b1)) dut (
        .clk(clk), .rst(rst), .empty(empty), .i_data(i_data), .pop(pop),
        .sw_start_trig(sw_start_trig), .sw_stop_trig(sw_stop_trig),
        .sw_clear_trig(sw_clear_trig), .sw_save_trig(sw_save_trig),
        .w_time_trig(w_time_trig), .sr04_dist_trig(sr04_dist_trig),
        .dht11_trig(dht11_trig), .set_hour(set_hour), .set_min(set_min),
        .set_sec(set_sec), .set_time_trig(set_time_trig), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [8:0]  pls;
        logic [16:0] hms;
    } ev_t;

    ev_t  q[$];
    ev_t  ev;
    byte  lb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   mh = 0, mm = 0, ms = 0;
    logic [8:0] obs;

    assign obs = {cmd_err, set_time_trig, dht11_trig, sr04_dist_trig,
                  w_time_trig, sw_save_trig, sw_clear_trig,
                  sw_stop_trig, sw_start_trig};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [16:0] mhms();
        return {mh[4:0], mm[5:0], ms[5:0]};
    endfunction

    function automatic byte upc(input byte c);
        return (c >= 8'h61 && c <= 8'h7A) ? byte'(c - 8'h20) : c;
    endfunction

    function automatic logic [8:0] letter(input byte c);
        case (c)
            8'h47:   return 9'h001;
            8'h50:   return 9'h002;
            8'h43:   return 9'h004;
            8'h56:   return 9'h008;
            8'h57:   return 9'h010;
            8'h55:   return 9'h020;
            8'h44:   return 9'h040;
            default: return 9'h000;
        endcase
    endfunction

    function automatic int dval(input byte c);
        return int'(c) - 48;
    endfunction

    task automatic push(input int ec, input logic [8:0] p);
        ev_t e;
        e.cyc = ec;
        e.pls = p;
        e.hms = mhms();
        q.push_back(e);
    endtask

    // Judge a complete line at its terminator.
    task automatic model_term(input int ec);
        int  n;
        byte c0;
        bit  alld;
        int  h, m, s;
        n = lb.size();
        if (n == 0) return;
        c0 = upc(lb[0]);
        if (n == 1 && letter(c0) != 9'h0) begin
            push(ec, letter(c0));
        end else if (c0 == 8'h54 && n == 7) begin
            alld = 1'b1;
            for (int i = 1; i < 7; i++)
                if (lb[i] < 8'h30 || lb[i] > 8'h39) alld = 1'b0;
            h = dval(lb[1]) * 10 + dval(lb[2]);
            m = dval(lb[3]) * 10 + dval(lb[4]);
            s = dval(lb[5]) * 10 + dval(lb[6]);
            if (alld && h <= 23 && m <= 59 && s <= 59) begin
                mh = h; mm = m; ms = s;
                push(ec, 9'h080);
            end else begin
                push(ec, 9'h100);
            end
        end else begin
            push(ec, 9'h100);
        end
    endtask

    task automatic put(input byte b);
        @(negedge clk);
        empty  = 1'b0;
        i_data = b;
        #1;
        chk("pop_hi", 32'(pop), 32'd1);
        if (b == 8'h0D || b == 8'h0A) begin
            model_term(cyc + 1);
            lb.delete();
        end else begin
            lb.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            empty = 1'b1;
        end
    endtask

    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (gap > 0) idle(gap);
            put(s[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        empty  = 1'b0;
        i_data = 8'h47;
        #1;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_pls", 32'(obs), 32'd0);
        @(negedge clk);
        chk("rst_hms", {set_hour, set_min, set_sec}, 32'd0);
        rst   = 1'b0;
        empty = 1'b1;
        lb.delete();
        mh = 0; mm = 0; ms = 0;
    endtask

    // Compare every observed pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                ev = q.pop_front();
                chk("missed_pls", 32'(0), 32'(ev.pls));
            end
            if (obs != 9'h0) begin
                if (q.size() == 0) begin
                    chk("unexp_pls", 32'(obs), 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("pls", 32'(obs), 32'(ev.pls));
                    chk("pls_cyc", cyc, ev.cyc);
                    chk("hms", {set_hour, set_min, set_sec}, 32'(ev.hms));
                end
            end
        end
    end

    initial begin
        do_reset();
        #1;
        chk("pop_empty", 32'(pop), 32'd0);
        send("G\r", 0);
        send("T235959\n", 0);
        send("T240000\r", 0);
        send("T1234\r", 0);
        send("T1234567\r", 0);
        send("X\r", 0);
        send("GG\r", 0);
        send("\r\n", 0);
        send("u\rd\rw\r", 0);
        send("P\rV\rC\r", 0);
        send("T125960\r", 0);
        send("T12a456\r", 0);
        send("T\r", 0);
        send("T073015\r", 3);
        send("t000000\r\n", 0);
        send("T195901\r", 0);
        idle(2);
        send("T12", 0);
        idle(2);
        do_reset();
        send("C\r", 0);
        idle(6);
        chk("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
